gf180mcu_fd_sc_mcu7t5v0__aoi_pipe: RTL and testbench
====================================================

Name: gf180mcu_fd_sc_mcu7t5v0__aoi_pipe

Overview:
- Parametrised, registered successor of the AOI211 cell function.
- CH independent channels; each computes ZN[i] = ~(&A-group[i] | B[i] | C[i]), where the AND group is A_W bits wide.
- Results leave through a valid/ready output stage with a 2-entry skid buffer, so upstream and downstream can stall independently at full throughput.
- Sits between datapath macros built from 7-track 5V cells where registered AOI decode with backpressure is needed.

Parameters:
- CH, 4, number of independent AOI channels (1..32).
- A_W, 2, AND-group width per channel (2..8); A_W=2 reproduces aoi211 per channel.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  synchronous active-low reset; sampled on rising CLK.
- IN_VALID  input  1  input word valid.
- IN_READY  output  1  block can accept an input word this cycle.
- A  input  CH*A_W  AND-group inputs; channel i uses A[i*A_W +: A_W].
- B  input  CH  OR input B per channel.
- C  input  CH  OR input C per channel.
- OUT_VALID  output  1  ZN holds a valid result.
- OUT_READY  input  1  downstream accepts ZN this cycle.
- ZN  output  CH  registered AOI result.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: RN=0 at a rising CLK edge clears state on that edge. Reset values: OUT_VALID=0, IN_READY=1, ZN=all 0s, skid buffer empty.
- Reset dominates every other event in that cycle. In-flight and skid data are discarded; none are presented after RN returns high.
- Function: f[i] = ~((AND of A[i*A_W +: A_W]) | B[i] | C[i]). It is pure combinational on the input word and is not registered until accepted.
- Accept: input transfer when IN_VALID & IN_READY at the rising edge. Output transfer when OUT_VALID & OUT_READY.
- Storage: main register M (drives ZN, OUT_VALID = M valid) and skid register S. IN_READY = !S_valid, driven straight from a flop with no combinational path from OUT_READY.
- States (M_valid, S_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and never reached.
- EMPTY:
  - accept → M=f, go ONE.
  - no accept → stay EMPTY.
- ONE, with acc = input accept and take = output transfer:
  - acc & take → M=f, stay ONE.
  - acc & !take → S=f, go FULL.
  - !acc & take → go EMPTY.
  - neither → hold.
- FULL (IN_READY=0, no accept possible):
  - take → M=S, go ONE.
  - no take → hold.
- Latency: 1 cycle. A word accepted at edge n is visible on ZN after edge n when the block was EMPTY, or in ONE with a simultaneous take.
- Throughput: 1 word/cycle when OUT_READY is held high.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- Stability: ZN and OUT_VALID hold while OUT_VALID & !OUT_READY.
- Ignored inputs: IN_VALID is ignored while IN_READY=0. A, B, C are don't-care when IN_VALID=0.
- ZN keeps its last value when OUT_VALID=0; it is not cleared on drain.

Optional Feature:
- Macro: GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN.
- Defined:
  - Adds output port LOW_CNT, 8 bits: a saturating count of output transfers whose ZN is all 0s.
  - Increments on such a transfer and stops at 255.
  - Synchronous clear by RN=0.
  - Does not affect the handshake or ZN timing.
- Not defined: the port and counter are absent; the block is otherwise identical.

Test Plan:
- Reset: drive RN=0 for 2 cycles with IN_VALID=1 → OUT_VALID=0, IN_READY=1, ZN=0 throughout; the first result appears only for a word accepted after RN=1.
- Truth table, CH=4, A_W=2, OUT_READY=1: A=8'b11_00_01_00, B=4'b0000, C=4'b0010 → ZN=4'b0101 one cycle later. Then sweep all 16 A/B/C combinations of one channel against the formula.
- Streaming: OUT_READY=1, 8 back-to-back words → 8 results on consecutive cycles, IN_READY constantly 1, correct order.
- Backpressure: OUT_READY=0, send 3 words → first 2 accepted, IN_READY=0 after the second, third held. Raise OUT_READY → results w0, w1, w2 in order, no loss.
- Simultaneous events in ONE: accept and take in the same cycle → state stays ONE and ZN updates to the new word. In FULL, take → S moves to M and IN_READY returns to 1 on the next cycle.
- Mid-operation reset, with the macro defined: in FULL with LOW_CNT=5, pulse RN=0 for 1 cycle → EMPTY, LOW_CNT=0, IN_READY=1. Then push 300 all-zero-ZN words (B=all 1s) → LOW_CNT saturates at 255.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// Registered multi-channel AOI211-style decode behind a valid/ready stage with a 2-entry skid.
// Define GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN to add the LOW_CNT all-zero transfer counter.
//
// state    | meaning
// ST_EMPTY | no word held, OUT_VALID=0
// ST_ONE   | main register M holds the head word
// ST_FULL  | M holds the head word, skid S holds the next one, IN_READY=0
module gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(
   parameter int CH  = 4,
   parameter int A_W = 2
) (
   input  logic              CLK,
   input  logic              RN,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [CH*A_W-1:0] A,
   input  logic [CH-1:0]     B,
   input  logic [CH-1:0]     C,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [CH-1:0]     ZN
`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
   ,
   output logic [7:0]        LOW_CNT
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CH-1:0] r_m;
   logic [CH-1:0] r_s;
   logic          r_in_ready;
   logic [CH-1:0] w_f;
   logic          w_acc;
   logic          w_take;
   logic          w_ld_m_f;
   logic          w_ld_m_s;
   logic          w_ld_s;

   always_comb begin
      w_f = '0;
      for (int i = 0; i < CH; i++) begin
         w_f[i] = ~((&A[i*A_W +: A_W]) | B[i] | C[i]);
      end
   end

   assign OUT_VALID = r_state[0];
   assign IN_READY  = r_in_ready;
   assign ZN        = r_m;
   assign w_acc     = IN_VALID & r_in_ready;
   assign w_take    = OUT_VALID & OUT_READY;

   always_comb begin
      w_state_nxt = r_state;
      w_ld_m_f    = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_ld_m_f    = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_acc && w_take) begin
               w_ld_m_f = 1'b1;
            end else if (w_acc) begin
               w_ld_s      = 1'b1;
               w_state_nxt = ST_FULL;
            end else if (w_take) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_take) begin
               w_ld_m_s    = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // IN_READY is registered from the next state so OUT_READY never reaches it combinationally.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_state    <= ST_EMPTY;
         r_m        <= '0;
         r_s        <= '0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
         if (w_ld_m_f) begin
            r_m <= w_f;
         end else if (w_ld_m_s) begin
            r_m <= r_s;
         end
         if (w_ld_s) begin
            r_s <= w_f;
         end
      end
   end

`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
   logic [7:0] r_low_cnt;

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_low_cnt <= 8'd0;
      end else if (w_take && (r_m == '0) && (r_low_cnt != 8'hFF)) begin
         r_low_cnt <= r_low_cnt + 8'd1;
      end
   end

   assign LOW_CNT = r_low_cnt;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// Bench for the AOI pipe: vector table, hand-written handshake sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe;

   localparam int CH  = 4;
   localparam int A_W = 2;

   logic              CLK;
   logic              RN;
   logic              IN_VALID;
   logic              IN_READY;
   logic [CH*A_W-1:0] A;
   logic [CH-1:0]     B;
   logic [CH-1:0]     C;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [CH-1:0]     ZN;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
   logic [7:0]        LOW_CNT;
`endif

   gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(.CH(CH), .A_W(A_W)) dut (
      .CLK       (CLK),
      .RN        (RN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .C         (C),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .ZN        (ZN)
`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
      ,
      .LOW_CNT   (LOW_CNT)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [CH-1:0] f_ref(input logic [CH*A_W-1:0] a,
                                           input logic [CH-1:0] b,
                                           input logic [CH-1:0] c);
      logic [CH-1:0] r;
      int unsigned   grp;
      int unsigned   full;
      full = (1 << A_W) - 1;
      r = '0;
      for (int i = 0; i < CH; i++) begin
         grp  = (int'(a) >> (i * A_W)) & full;
         r[i] = !((grp == full) || b[i] || c[i]);
      end
      return r;
   endfunction

   // Reference model: a 2-deep FIFO of results; the head is what ZN must show.
   logic [CH-1:0] m_q[$];
   logic [CH-1:0] m_last;
   int            m_cnt;

   always @(posedge CLK) begin
      logic          acc;
      logic          take;
      logic [CH-1:0] w;
      if (!RN) begin
         m_q.delete();
         m_last = '0;
         m_cnt  = 0;
      end else begin
         acc  = IN_VALID && (m_q.size() < 2);
         take = (m_q.size() > 0) && OUT_READY;
         if (take) begin
            w = m_q.pop_front();
            if (w == '0 && m_cnt < 255) m_cnt = m_cnt + 1;
         end
         if (acc) m_q.push_back(f_ref(A, B, C));
         if (m_q.size() > 0) m_last = m_q[0];
      end
   end

   int n_checks;
   int n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic [CH-1:0] exp_zn;
      @(posedge CLK);
      @(negedge CLK);
      exp_zn = (m_q.size() > 0) ? m_q[0] : m_last;
      chk("model_out_valid", 32'(OUT_VALID), 32'(m_q.size() > 0));
      chk("model_in_ready",  32'(IN_READY),  32'(m_q.size() < 2));
      chk("model_zn",        32'(ZN),        32'(exp_zn));
`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
      chk("model_low_cnt",   32'(LOW_CNT),   32'(m_cnt));
`endif
   endtask

   typedef struct {
      logic [CH*A_W-1:0] a;
      logic [CH-1:0]     b;
      logic [CH-1:0]     c;
      logic [CH-1:0]     zn;
   } vec_t;

   vec_t vecs[17];

   initial begin
      logic [1:0]        a0;
      logic              b0;
      logic              c0;
      logic [CH-1:0]     zw0, zw1, zw2;

      n_checks = 0;
      n_err    = 0;

      vecs[0] = '{a: 8'b11_00_01_00, b: 4'b0000, c: 4'b0010, zn: 4'b0101};
      for (int k = 0; k < 16; k++) begin
         a0 = k[1:0];
         b0 = k[2];
         c0 = k[3];
         vecs[k+1].a  = {6'b0, a0};
         vecs[k+1].b  = {3'b0, b0};
         vecs[k+1].c  = {3'b0, c0};
         vecs[k+1].zn = {3'b111, (a0 != 2'b11) && !b0 && !c0};
      end

      // Reset held with IN_VALID asserted
      RN        = 1'b0;
      IN_VALID  = 1'b1;
      A         = '1;
      B         = '0;
      C         = '0;
      OUT_READY = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
         chk("rst_in_ready",  32'(IN_READY),  32'd1);
         chk("rst_zn",        32'(ZN),        32'd0);
      end
      RN       = 1'b1;
      IN_VALID = 1'b0;
      tick();
      chk("post_rst_no_word", 32'(OUT_VALID), 32'd0);

      // Truth table, one word per cycle
      for (int k = 0; k < 17; k++) begin
         IN_VALID = 1'b1;
         A = vecs[k].a;
         B = vecs[k].b;
         C = vecs[k].c;
         tick();
         chk("tt_out_valid", 32'(OUT_VALID), 32'd1);
         chk("tt_zn",        32'(ZN),        32'(vecs[k].zn));
      end
      IN_VALID = 1'b0;
      tick();

      // Streaming 8 back-to-back words
      for (int k = 0; k < 8; k++) begin
         IN_VALID = 1'b1;
         A = CH*A_W'($urandom);
         B = CH'($urandom);
         C = CH'($urandom);
         tick();
         chk("stream_in_ready", 32'(IN_READY), 32'd1);
      end
      IN_VALID = 1'b0;
      tick();
      chk("stream_drained", 32'(OUT_VALID), 32'd0);

      // Backpressure: three words with OUT_READY low
      zw0 = 4'b1111;
      zw1 = 4'b1110;
      zw2 = 4'b1100;
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      A = '0; B = 4'b0000; C = '0;
      tick();
      chk("bp_w0_in_ready", 32'(IN_READY), 32'd1);
      B = 4'b0001;
      tick();
      chk("bp_full_in_ready", 32'(IN_READY), 32'd0);
      chk("bp_full_zn",       32'(ZN),       32'(zw0));
      B = 4'b0011;
      tick();
      chk("bp_hold_in_ready", 32'(IN_READY), 32'd0);
      chk("bp_hold_zn",       32'(ZN),       32'(zw0));
      OUT_READY = 1'b1;
      tick();
      chk("bp_skid_to_main", 32'(ZN),       32'(zw1));
      chk("bp_ready_back",   32'(IN_READY), 32'd1);
      tick();
      chk("bp_acc_take_zn",  32'(ZN),        32'(zw2));
      chk("bp_acc_take_one", 32'(OUT_VALID), 32'd1);
      IN_VALID = 1'b0;
      tick();
      chk("bp_drain_valid", 32'(OUT_VALID), 32'd0);
      chk("bp_drain_zn",    32'(ZN),        32'(zw2));

      // Random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         RN        = ($urandom_range(0, 99) != 0);
         IN_VALID  = $urandom_range(0, 1) == 1;
         OUT_READY = $urandom_range(0, 3) != 0;
         A = CH*A_W'($urandom);
         B = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
         C = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
         tick();
      end
      RN       = 1'b1;
      IN_VALID = 1'b0;

`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI_PIPE_LOWCNT_EN
      RN = 1'b0;
      tick();
      RN = 1'b1;
      OUT_READY = 1'b1;
      IN_VALID  = 1'b1;
      A = '0; B = '1; C = '0;
      for (int k = 0; k < 5; k++) tick();
      IN_VALID = 1'b0;
      tick();
      chk("lc_five", 32'(LOW_CNT), 32'd5);
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      tick();
      tick();
      chk("lc_full_in_ready", 32'(IN_READY), 32'd0);
      chk("lc_full_cnt",      32'(LOW_CNT),  32'd5);
      RN = 1'b0;
      tick();
      chk("lc_rst_valid",    32'(OUT_VALID), 32'd0);
      chk("lc_rst_in_ready", 32'(IN_READY),  32'd1);
      chk("lc_rst_cnt",      32'(LOW_CNT),   32'd0);
      RN = 1'b1;
      OUT_READY = 1'b1;
      for (int k = 0; k < 300; k++) tick();
      IN_VALID = 1'b0;
      tick();
      tick();
      chk("lc_saturate", 32'(LOW_CNT), 32'd255);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
